omega_network_bp: RTL and testbench

- Parametrised, buffered successor to omega_network_ff: an N-port self-routing omega network with per-packet destination addresses, per-stage FIFO buffering, round-robin conflict arbitration and end-to-end backpressure.
- Sits between N producer lanes and N consumer lanes, e.g. scatter of sparse-matrix words to bank ports.
- Replaces the global `control` word and the lossless-only assumption of the flip-flop network.

---
 rtl/omega_network_bp_pkg.sv | 27 ++
 rtl/omega_switch_2x2.sv | 115 +++++++++++
 rtl/omega_network_bp.sv | 99 +++++++++
 tb/tb_omega_network_bp.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/omega_network_bp_pkg.sv
// Shared helpers for the buffered omega network: integer log2, the
// perfect-shuffle index mapping and the width of a queued {addr, data} entry.
package omega_pkg;

    function automatic int omega_log2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((32'sd1 <<< k) < n) begin
                r = k + 1;
            end
        end
        return r;
    endfunction

    // Perfect shuffle: rotate the position left by one over aw bits.
    function automatic int shuffle_idx(input int p, input int aw);
        return ((p << 1) | (p >> (aw - 1))) & ((32'sd1 <<< aw) - 32'sd1);
    endfunction

    function automatic int entry_width(input int width, input int aw);
        return width + aw;
    endfunction

    localparam int ENTRY_W = entry_width(32'sd8, omega_log2(32'sd8));

endpackage

// File: rtl/omega_switch_2x2.sv
// One 2x2 switching element: two input FIFOs of {addr, data}, destination-bit
// steering and a round-robin arbiter per output with ready/valid handshakes.
module omega_switch_2x2
    import omega_pkg::*;
#(
    parameter int EW        = 11,
    parameter int ROUTE_BIT = 10,
    parameter int DEPTH     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    up_valid,
    input  logic [2*EW-1:0] up_entry,
    output logic [1:0]    up_full,
    output logic [1:0]    dn_valid,
    output logic [2*EW-1:0] dn_entry,
    input  logic [1:0]    dn_ready
);

    localparam int PW = (DEPTH > 1) ? omega_log2(DEPTH) : 1;
    localparam int CW = omega_log2(DEPTH) + 1;
    localparam logic [PW-1:0] PTR_INC = (DEPTH > 1) ? PW'(32'd1) : PW'(32'd0);

    logic [EW-1:0] mem_r    [2][DEPTH];
    logic [PW-1:0] rd_ptr_r [2];
    logic [PW-1:0] wr_ptr_r [2];
    logic [CW-1:0] count_r  [2];
    logic [CW-1:0] count_next_s [2];
    logic [1:0]    full_r;
    logic [1:0]    ptr_r;
    logic [EW-1:0] head_s   [2];
    logic [1:0]    req_s    [2];
    logic [1:0]    nonempty_s, route_s, wr_s, rd_s, contest_s, winner_s;

    assign up_full = full_r;

    // Head decode, arbitration and the resulting FIFO read/write strobes.
    always_comb begin
        nonempty_s = 2'b00;
        route_s    = 2'b00;
        wr_s       = 2'b00;
        rd_s       = 2'b00;
        contest_s  = 2'b00;
        winner_s   = 2'b00;
        dn_valid   = 2'b00;
        dn_entry   = '0;
        for (int i = 0; i < 2; i++) begin
            head_s[i]       = mem_r[i][rd_ptr_r[i]];
            nonempty_s[i]   = (count_r[i] != '0);
            route_s[i]      = head_s[i][ROUTE_BIT];
            wr_s[i]         = up_valid[i] & ~full_r[i];
            count_next_s[i] = count_r[i];
        end
        for (int j = 0; j < 2; j++) begin
            req_s[j][0] = nonempty_s[0] && (route_s[0] == 1'(j));
            req_s[j][1] = nonempty_s[1] && (route_s[1] == 1'(j));
            contest_s[j] = &req_s[j];
            if (contest_s[j]) begin
                winner_s[j] = ptr_r[j];
            end else begin
                winner_s[j] = req_s[j][1];
            end
            dn_valid[j] = |req_s[j];
            if (winner_s[j]) begin
                dn_entry[j*EW +: EW] = head_s[1];
            end else begin
                dn_entry[j*EW +: EW] = head_s[0];
            end
        end
        for (int i = 0; i < 2; i++) begin
            rd_s[i] = nonempty_s[i] && (winner_s[route_s[i]] == 1'(i)) && dn_ready[route_s[i]];
            count_next_s[i] = count_r[i] + CW'(wr_s[i]) - CW'(rd_s[i]);
        end
    end

    // FIFO storage; emptiness is tracked by the counters, so no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= up_entry[i*EW +: EW];
            end
        end
    end

    // FIFO pointers, occupancy, registered full flags and arbiter pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr_r[i] <= '0;
                wr_ptr_r[i] <= '0;
                count_r[i]  <= '0;
            end
            full_r <= 2'b00;
            ptr_r  <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + PTR_INC;
                end
                if (rd_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_INC;
                end
                count_r[i] <= count_next_s[i];
                full_r[i]  <= (count_next_s[i] == CW'(DEPTH));
            end
            // Only a contested transfer that actually completes hands priority over.
            for (int j = 0; j < 2; j++) begin
                if (contest_s[j] && dn_ready[j]) begin
                    ptr_r[j] <= ~ptr_r[j];
                end
            end
        end
    end

endmodule

// File: rtl/omega_network_bp.sv
// N-port self-routing omega network with per-stage FIFO buffering, round-robin
// arbitration and end-to-end backpressure from the consumer pop signals.
module omega_network_bp
    import omega_pkg::*;
#(
    parameter  int WIDTH            = 8,
    parameter  int IN_PORTS         = 8,
    parameter  int DEPTH            = 2,
    localparam int ADDR_WIDTH_PORTS = omega_log2(IN_PORTS),
    localparam int OUT_PORTS        = IN_PORTS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [0:IN_PORTS-1]                  push,
    input  logic [IN_PORTS*WIDTH-1:0]            d_in,
    input  logic [IN_PORTS*ADDR_WIDTH_PORTS-1:0] addr_in,
    output logic [0:IN_PORTS-1]                  full,
    output logic                                 drop_err,
    output logic [0:OUT_PORTS-1]                 valid,
    output logic [OUT_PORTS*WIDTH-1:0]           d_out,
    input  logic [0:OUT_PORTS-1]                 pop
);

    localparam int N  = IN_PORTS;
    localparam int AW = ADDR_WIDTH_PORTS;
    localparam int EW = entry_width(WIDTH, AW);

    logic [N-1:0]    st_in_valid_s  [AW];
    logic [N*EW-1:0] st_in_entry_s  [AW];
    logic [N-1:0]    st_full_s      [AW];
    logic [N-1:0]    st_out_valid_s [AW];
    logic [N*EW-1:0] st_out_entry_s [AW];
    logic [N-1:0]    st_out_ready_s [AW];

    logic [0:N-1]       valid_r;
    logic [N*WIDTH-1:0] d_out_r;
    logic               drop_err_r;

    assign valid    = valid_r;
    assign d_out    = d_out_r;
    assign drop_err = drop_err_r;

    for (genvar s = 0; s < AW; s++) begin : g_stage
        for (genvar p = 0; p < N; p++) begin : g_wire
            localparam int Q = shuffle_idx(p, AW);
            if (s == 0) begin : g_src
                assign st_in_valid_s[0][Q]          = push[p];
                assign st_in_entry_s[0][Q*EW +: EW] = {addr_in[p*AW +: AW], d_in[p*WIDTH +: WIDTH]};
                assign full[p]                      = st_full_s[0][Q];
            end else begin : g_link
                assign st_in_valid_s[s][Q]          = st_out_valid_s[s-1][p];
                assign st_in_entry_s[s][Q*EW +: EW] = st_out_entry_s[s-1][p*EW +: EW];
                assign st_out_ready_s[s-1][p]       = ~st_full_s[s][Q];
            end
        end
        for (genvar k = 0; k < N/2; k++) begin : g_sw
            omega_switch_2x2 #(
                .EW        (EW),
                .ROUTE_BIT (WIDTH + AW - 1 - s),
                .DEPTH     (DEPTH)
            ) u_sw (
                .clk      (clk),
                .rst      (rst),
                .up_valid (st_in_valid_s[s][2*k +: 2]),
                .up_entry (st_in_entry_s[s][2*k*EW +: 2*EW]),
                .up_full  (st_full_s[s][2*k +: 2]),
                .dn_valid (st_out_valid_s[s][2*k +: 2]),
                .dn_entry (st_out_entry_s[s][2*k*EW +: 2*EW]),
                .dn_ready (st_out_ready_s[s][2*k +: 2])
            );
        end
    end

    for (genvar o = 0; o < N; o++) begin : g_out_ready
        assign st_out_ready_s[AW-1][o] = ~valid_r[o] | pop[o];
    end

    // Output registers hold their word until popped; drop_err is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r    <= '0;
            d_out_r    <= '0;
            drop_err_r <= 1'b0;
        end else begin
            for (int o = 0; o < N; o++) begin
                if (~valid_r[o] | pop[o]) begin
                    valid_r[o] <= st_out_valid_s[AW-1][o];
                    if (st_out_valid_s[AW-1][o]) begin
                        d_out_r[o*WIDTH +: WIDTH] <= st_out_entry_s[AW-1][o*EW +: WIDTH];
                    end
                end
            end
            if (|(push & full)) begin
                drop_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_omega_network_bp.sv
// Directed self-checking bench for omega_network_bp (8 ports, 8-bit words, depth 2).
module tb_omega_network_bp;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:7]  push;
    logic [63:0] d_in;
    logic [23:0] addr_in;
    logic [0:7]  full;
    logic        drop_err;
    logic [0:7]  valid;
    logic [63:0] d_out;
    logic [0:7]  pop;

    int checks = 0;
    int errors = 0;

    int cnt, first, last, dup, others, n, na, nb, bad;
    logic [7:0]  mask;
    logic [7:0]  idx;
    logic [7:0]  seq [16];
    logic [63:0] exp_vec;

    always #5 clk = ~clk;

    omega_network_bp dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .d_in     (d_in),
        .addr_in  (addr_in),
        .full     (full),
        .drop_err (drop_err),
        .valid    (valid),
        .d_out    (d_out),
        .pop      (pop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    initial begin
        rst = 1'b1; push = '0; d_in = '0; addr_in = '0; pop = '1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_dout", d_out, 64'h0);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_drop", 64'(drop_err), 64'h0);

        // Identity permutation: one word per input, 3-cycle latency.
        for (int i = 0; i < 8; i++) begin
            addr_in[i*3 +: 3] = 3'(i);
            d_in[i*8 +: 8]    = 8'(i);
        end
        push = '1; tick(); push = '0;
        tick(); chk("id_lat1", 64'(valid), 64'h0);
        tick(); chk("id_lat2", 64'(valid), 64'h0);
        tick(); chk("id_valid", 64'(valid), 64'hFF);
        for (int o = 0; o < 8; o++) chk("id_data", 64'(d_out[o*8 +: 8]), 64'(o));
        tick(); chk("id_drain", 64'(valid), 64'h0);

        // Cyclic shift by one, streamed for 10 cycles.
        exp_vec = '0;
        for (int i = 0; i < 8; i++) begin
            addr_in[i*3 +: 3] = 3'((i + 1) % 8);
            d_in[i*8 +: 8]    = 8'h20 + 8'(i);
            exp_vec[i*8 +: 8] = 8'h20 + 8'((i + 7) % 8);
        end
        push = '1;
        for (int c = 0; c < 13; c++) begin
            tick();
            if (c == 9) push = '0;
            if (c >= 3) begin
                chk("cyc_valid", 64'(valid), 64'hFF);
                chk("cyc_data", d_out, exp_vec);
            end else begin
                chk("cyc_fill", 64'(valid), 64'h0);
            end
        end
        tick(); chk("cyc_drain", 64'(valid), 64'h0);

        // Hotspot: every input targets output 0.
        for (int i = 0; i < 8; i++) begin
            addr_in[i*3 +: 3] = 3'd0;
            d_in[i*8 +: 8]    = 8'h10 + 8'(i);
        end
        push = '1; tick(); push = '0;
        cnt = 0; first = -1; last = -1; dup = 0; others = 0; mask = 8'h00;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (valid[0]) begin
                cnt++;
                idx = d_out[7:0] - 8'h10;
                if (idx < 8'd8 && !mask[idx[2:0]]) mask[idx[2:0]] = 1'b1;
                else dup++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (valid[1:7] != 7'd0) others++;
        end
        chk("hot_count", 64'(cnt), 64'd8);
        chk("hot_mask", 64'(mask), 64'hFF);
        chk("hot_dup", 64'(dup), 64'd0);
        chk("hot_others", 64'(others), 64'd0);
        chk("hot_first", 64'(first), 64'd3);
        chk("hot_span", 64'(last - first), 64'd7);
        chk("hot_drop", 64'(drop_err), 64'h0);

        // Backpressure: output 5 stalled, input 2 pushes 0..9.
        pop = '1; pop[5] = 1'b0;
        addr_in[2*3 +: 3] = 3'd5;
        for (int k = 0; k < 10; k++) begin
            chk("bp_full", 64'(full[2]), 64'(k >= 7));
            d_in[2*8 +: 8] = 8'(k);
            push = '0; push[2] = 1'b1;
            tick();
        end
        push = '0;
        chk("bp_drop", 64'(drop_err), 64'h1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_stall_valid", 64'(valid[5]), 64'h1);
            chk("bp_stall_data", 64'(d_out[5*8 +: 8]), 64'h0);
        end
        pop[5] = 1'b1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            if (valid[5]) begin
                if (n < 16) seq[n] = d_out[5*8 +: 8];
                n++;
            end
            tick();
        end
        chk("bp_count", 64'(n), 64'd7);
        for (int j = 0; j < 7; j++) chk("bp_order", 64'(seq[j]), 64'(j));

        // Reset two cycles after identity pushes discards everything in flight.
        for (int i = 0; i < 8; i++) begin
            addr_in[i*3 +: 3] = 3'(i);
            d_in[i*8 +: 8]    = 8'(i);
        end
        push = '1; tick(); push = '0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_valid", 64'(valid), 64'h0);
        chk("mid_dout", d_out, 64'h0);
        chk("mid_full", 64'(full), 64'h0);
        chk("mid_drop", 64'(drop_err), 64'h0);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (valid != 8'h00) bad++;
        end
        chk("mid_quiet", 64'(bad), 64'd0);

        // Fairness: inputs 0 and 4 contend at stage 0 for output 3.
        addr_in[0*3 +: 3] = 3'd3;
        addr_in[4*3 +: 3] = 3'd3;
        na = 0; nb = 0; n = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid[3]) begin
                if (n < 16) seq[n] = d_out[3*8 +: 8];
                n++;
            end
            push = '0;
            if (na < 4 && !full[0]) begin
                push[0] = 1'b1; d_in[0*8 +: 8] = 8'hA0 + 8'(na); na++;
            end
            if (nb < 4 && !full[4]) begin
                push[4] = 1'b1; d_in[4*8 +: 8] = 8'hB0 + 8'(nb); nb++;
            end
            tick();
        end
        push = '0;
        chk("fair_count", 64'(n), 64'd8);
        for (int j = 0; j < 8; j++) begin
            if (j % 2 == 0) chk("fair_order", 64'(seq[j]), 64'(8'hA0 + 8'(j / 2)));
            else            chk("fair_order", 64'(seq[j]), 64'(8'hB0 + 8'(j / 2)));
        end
        chk("fair_drop", 64'(drop_err), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
